// File: rtl/pkt_to_msg_arbiter_if.sv
// Request/grant and converter-control bundle between the flits_buffer array,
// the shared packet-to-message converter and the arbiter that sequences them.
interface pkt_to_msg_arbiter_if #(
  parameter int N_BUFFERS  = 4,
  parameter int N_BITS_SEL = $clog2(N_BUFFERS)
);
  logic [N_BUFFERS-1:0]  r_pkt_to_msg_i;
  logic [N_BUFFERS-1:0]  g_pkt_to_msg_o;
  logic                  conv_ready_i;
  logic                  conv_done_i;
  logic                  conv_start_o;
  logic [N_BITS_SEL-1:0] conv_sel_o;
  logic                  busy_o;
  logic                  timeout_o;
  logic [15:0]           pkt_count_o;

  modport master (
    input  r_pkt_to_msg_i, conv_ready_i, conv_done_i,
    output g_pkt_to_msg_o, conv_start_o, conv_sel_o, busy_o, timeout_o, pkt_count_o
  );

  modport slave (
    output r_pkt_to_msg_i, conv_ready_i, conv_done_i,
    input  g_pkt_to_msg_o, conv_start_o, conv_sel_o, busy_o, timeout_o, pkt_count_o
  );
endinterface

// File: rtl/pkt_to_msg_arbiter.sv
// Round-robin arbiter that shares one packet-to-message converter among
// N_BUFFERS flits_buffer requesters, with a watchdog on converter completion.
module pkt_to_msg_arbiter #(
  parameter int N_BUFFERS  = 4,
  parameter int N_BITS_SEL = $clog2(N_BUFFERS),
  parameter int TIMEOUT    = 64
) (
  input logic clk,
  input logic rst,
  pkt_to_msg_arbiter_if.master bus
);

  // state     | meaning
  // IDLE      | waiting for converter ready and any request
  // GRANT     | one-cycle grant + start strobe to the winner
  // WAIT_DONE | converter busy; watchdog running until done or expiry
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE} state_t;

  localparam int W = N_BITS_SEL + 1;

  state_t                state_q, state_d;
  logic [N_BITS_SEL-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_BITS_SEL-1:0] sel_q, sel_d;
  logic [N_BITS_SEL-1:0] winner, sel_inc, cand;
  logic [W-1:0]          idx_w;
  logic                  found;
  logic [N_BUFFERS-1:0]  grant_q, grant_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic [15:0]           wd_q, wd_d;

  // Rotating-priority scan; the modulo is done by subtraction so that
  // non-power-of-two buffer counts never produce an out-of-range index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx_w  = '0;
    cand   = '0;
    for (int i = 0; i < N_BUFFERS; i++) begin
      idx_w = {1'b0, rr_ptr_q} + W'(i);
      if (idx_w >= W'(N_BUFFERS)) idx_w = idx_w - W'(N_BUFFERS);
      cand = idx_w[N_BITS_SEL-1:0];
      if (!found && bus.r_pkt_to_msg_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel_inc = (sel_q == N_BITS_SEL'(N_BUFFERS - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    grant_d     = '0;
    start_d     = 1'b0;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    pkt_count_d = pkt_count_q;
    wd_d        = wd_q;
    case (state_q)
      IDLE: begin
        if (bus.conv_ready_i && (bus.r_pkt_to_msg_i != '0)) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = {{(N_BUFFERS-1){1'b0}}, 1'b1} << winner;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        state_d = WAIT_DONE;
        wd_d    = 16'(TIMEOUT - 1);
      end
      WAIT_DONE: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (bus.conv_done_i) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          rr_ptr_d    = sel_inc;
          pkt_count_d = pkt_count_q + 16'd1;
        end else if (wd_q == '0) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          rr_ptr_d  = sel_inc;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pkt_count_q <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      pkt_count_q <= pkt_count_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.g_pkt_to_msg_o = grant_q;
  assign bus.conv_start_o   = start_q;
  assign bus.conv_sel_o     = sel_q;
  assign bus.busy_o         = busy_q;
  assign bus.timeout_o      = timeout_q;
  assign bus.pkt_count_o    = pkt_count_q;

endmodule

// File: doc/pkt_to_msg_arbiter.md
# pkt_to_msg_arbiter

Round-robin arbiter and sequencer sharing one packet-to-message converter among `N_BUFFERS` `flits_buffer` instances on the NIC receive side. It collects each buffer's `r_pkt_to_msg_o` request and issues a one-cycle `g_pkt_to_msg_i` grant to exactly one buffer. It drives the converter's input mux select and start strobe, then holds the converter until it reports completion or a watchdog expires. Packets are served fairly, one at a time, in rotating priority order.

## Interface
- `N_BUFFERS`, 4: number of flits_buffer requesters (2..16; need not be a power of two).
- `N_BITS_SEL`, `clog2(N_BUFFERS)` = 2: width of the buffer index.
- `TIMEOUT`, 64: maximum number of cycles in WAIT_DONE before abort (2..65535).
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `r_pkt_to_msg_i` in `N_BUFFERS`: per-buffer request. Bit i is `r_pkt_to_msg_o` of buffer i.
- `g_pkt_to_msg_o` out `N_BUFFERS`: per-buffer grant, one-hot or zero. Bit i drives `g_pkt_to_msg_i` of buffer i.
- `conv_ready_i` in 1: converter is idle and able to accept a packet.
- `conv_done_i` in 1: converter one-cycle pulse indicating the message is complete.
- `conv_start_o` out 1: one-cycle start strobe to the converter.
- `conv_sel_o` out `N_BITS_SEL`: index of the buffer whose `out_link_o` the converter reads.
- `busy_o` out 1: high while in GRANT or WAIT_DONE.
- `timeout_o` out 1: one-cycle pulse when the watchdog aborts a transfer.
- `pkt_count_o` out 16: number of packets completed, wraps modulo 2^16.

## Operation
- States and transitions:
  - IDLE → GRANT when `conv_ready_i` is high and `r_pkt_to_msg_i` is non-zero.
  - GRANT → WAIT_DONE unconditionally, after one cycle.
  - WAIT_DONE → IDLE on `conv_done_i` or on watchdog expiry.
- Winner selection: the first set request bit scanning `rr_ptr`, `rr_ptr+1`, …, wrapping from `N_BUFFERS-1` to 0. The winner index is latched into `conv_sel_o` on the IDLE→GRANT edge.
- GRANT cycle: `g_pkt_to_msg_o[winner]=1` and `conv_start_o=1`. Both are registered and high for exactly one cycle.
- WAIT_DONE:
  - `conv_sel_o` is held stable and all grants are 0.
  - The watchdog counter starts at 0 and increments each cycle.
  - `conv_done_i` is honored only in WAIT_DONE; a pulse in IDLE or GRANT is ignored.
- On exit from WAIT_DONE, by either cause:
  - `rr_ptr` ← winner+1, wrapping to 0 when winner = `N_BUFFERS-1`.
  - Exit on done: `pkt_count_o` increments by 1.
- Watchdog:
  - Expires when the counter equals `TIMEOUT-1` and `conv_done_i` is low.
  - On expiry, `timeout_o` pulses for one cycle, registered and coincident with the first IDLE cycle, and `pkt_count_o` is unchanged.
- `conv_done_i` on the same cycle as expiry: done wins, with no timeout pulse.
- Requests that drop between sampling and grant are not re-checked. The grant is still issued.
- Indices ≥ `N_BUFFERS` are never produced.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `g_pkt_to_msg_o`=0, `conv_start_o`=0, `conv_sel_o`=0, `busy_o`=0, `timeout_o`=0, `pkt_count_o`=0, watchdog=0.
- Request to grant latency: 1 cycle. A request and ready sampled at edge t produce the grant during cycle t..t+1.
- Done sampled at edge d → IDLE at d. The earliest next grant is asserted at edge d+1. Back-to-back packet spacing is therefore at least 3 cycles.
- `busy_o` is asserted from the GRANT edge through the cycle before IDLE.
- Reset asserted mid-operation (GRANT or WAIT_DONE): at the next edge all outputs take their reset values. Any in-flight grant is dropped and the count is not incremented.

## Test plan
- Single request, `N_BUFFERS`=4:
  - Stimulus: `r_pkt_to_msg_i`=4'b0100, `conv_ready_i`=1, `conv_done_i` pulsed 3 cycles after GRANT.
  - Required: `g_pkt_to_msg_o`=4'b0100 for 1 cycle, `conv_start_o` coincident, `conv_sel_o`=2. Then `pkt_count_o`=1 and `rr_ptr`=3.
- Round robin, all requests held at 4'b1111, done returned promptly:
  - Required: grant order is buffers 0,1,2,3,0, and `pkt_count_o` reaches 5.
- Wrap-around: `rr_ptr`=3 with requests 4'b1001.
  - Required: buffer 3 is granted first, then buffer 0.
- Ready gating: requests 4'b0010 with `conv_ready_i`=0 for 5 cycles, then 1.
  - Required: no grant while ready is low; the grant comes 1 cycle after ready rises.
- Watchdog, `TIMEOUT`=8: grant issued, `conv_done_i` never asserted.
  - Required: `timeout_o` pulses once, 8 cycles after entering WAIT_DONE. `pkt_count_o` is unchanged and `rr_ptr` advances past the winner.
- Done on the expiry cycle and reset in WAIT_DONE:
  - Done coincident with expiry: count increments and there is no timeout pulse.
  - `rst`=1 for 1 cycle in WAIT_DONE: all outputs are 0 on the next cycle.
